ssemi_cic_interpolator: RTL



---
 rtl/ssemi_cic_interpolator.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ssemi_cic_interpolator.sv
`default_nettype none
// ============================================================================
// ssemi_cic_interpolator : CIC interpolator (combs at input rate, zero-stuff,
//                          integrators at output rate) with valid/ready I/O.
// Revision: 1.0
// ============================================================================
module ssemi_cic_interpolator #(
   parameter int CIC_STAGES         = 3,
   parameter int INTERP_FACTOR      = 8,
   parameter int DIFFERENTIAL_DELAY = 1,
   parameter int INPUT_DATA_WIDTH   = 24,
   parameter int OUTPUT_DATA_WIDTH  = 16
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_enable,
   input  logic                                i_valid,
   output logic                                o_ready,
   input  logic [INPUT_DATA_WIDTH-1:0]         i_data,
   output logic [OUTPUT_DATA_WIDTH-1:0]        o_data,
   output logic                                o_valid,
   input  logic                                i_ready,
   output logic                                o_underflow,
   output logic                                o_busy,
   output logic [$clog2(INTERP_FACTOR)-1:0]    o_phase
);

   localparam int c_log2_r  = $clog2(INTERP_FACTOR);
   localparam int c_log2_rm = $clog2(INTERP_FACTOR * DIFFERENTIAL_DELAY);
   localparam int c_w       = INPUT_DATA_WIDTH + CIC_STAGES * c_log2_rm;
   localparam int c_shift   = CIC_STAGES * c_log2_rm - c_log2_r
                              + INPUT_DATA_WIDTH - OUTPUT_DATA_WIDTH;
   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_run  = 1'b1;
   localparam logic [c_log2_r-1:0] c_phase_last = c_log2_r'(INTERP_FACTOR - 1);

   logic [0:0]                   state_q, state_d;
   logic                         buf_full_q, buf_full_d;
   logic [INPUT_DATA_WIDTH-1:0]  buf_data_q, buf_data_d;
   logic [c_log2_r-1:0]          phase_q, phase_d;
   logic [OUTPUT_DATA_WIDTH-1:0] data_q, data_d;
   logic signed [c_w-1:0]        dly_q   [CIC_STAGES][DIFFERENTIAL_DELAY];
   logic signed [c_w-1:0]        dly_d   [CIC_STAGES][DIFFERENTIAL_DELAY];
   logic signed [c_w-1:0]        integ_q [CIC_STAGES];
   logic signed [c_w-1:0]        integ_d [CIC_STAGES];
   logic signed [c_w-1:0]        w_comb  [CIC_STAGES+1];
   logic signed [c_w-1:0]        w_x;
   logic                         w_run, w_step, w_phase0, w_consume, w_accept;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= c_st_idle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_idle: if (i_enable && buf_full_q) state_d = c_st_run;
         c_st_run:  if (!i_enable)              state_d = c_st_idle;
         default:   state_d = c_st_idle;
      endcase
   end

   // Ready is gated by reset so the port reads 0 the moment reset asserts.
   always_comb begin
      w_run       = (state_q == c_st_run);
      o_busy      = w_run;
      o_valid     = w_run && i_enable;
      w_step      = w_run && i_enable && i_ready;
      w_phase0    = (phase_q == '0);
      w_consume   = w_step && w_phase0;
      o_ready     = i_enable && !i_rst && (!buf_full_q || w_consume);
      o_underflow = w_consume && !buf_full_q;
      w_accept    = i_valid && o_ready;
   end

   // An empty buffer feeds zero through the combs, which still shift.
   always_comb begin
      w_comb[0] = buf_full_q ?
                  {{(c_w-INPUT_DATA_WIDTH){buf_data_q[INPUT_DATA_WIDTH-1]}}, buf_data_q} : '0;
      for (int k = 0; k < CIC_STAGES; k++)
         w_comb[k+1] = w_comb[k] - dly_q[k][DIFFERENTIAL_DELAY-1];
      w_x = w_phase0 ? w_comb[CIC_STAGES] : '0;
   end

   always_comb begin
      buf_full_d = buf_full_q;
      buf_data_d = buf_data_q;
      phase_d    = phase_q;
      data_d     = data_q;
      dly_d      = dly_q;
      integ_d    = integ_q;
      if (!i_enable) begin
         buf_full_d = 1'b0;
         buf_data_d = '0;
         phase_d    = '0;
         data_d     = '0;
         for (int k = 0; k < CIC_STAGES; k++) begin
            integ_d[k] = '0;
            for (int j = 0; j < DIFFERENTIAL_DELAY; j++) dly_d[k][j] = '0;
         end
      end else begin
         if (w_step) begin
            integ_d[0] = integ_q[0] + w_x;
            for (int k = 1; k < CIC_STAGES; k++)
               integ_d[k] = integ_q[k] + integ_q[k-1];
            data_d  = OUTPUT_DATA_WIDTH'(integ_d[CIC_STAGES-1] >>> c_shift);
            phase_d = (phase_q == c_phase_last) ? '0 : phase_q + c_log2_r'(1);
            if (w_phase0) begin
               for (int k = 0; k < CIC_STAGES; k++) begin
                  dly_d[k][0] = w_comb[k];
                  for (int j = 1; j < DIFFERENTIAL_DELAY; j++) dly_d[k][j] = dly_q[k][j-1];
               end
            end
         end
         if (w_accept) begin
            buf_full_d = 1'b1;
            buf_data_d = i_data;
         end else if (w_consume) begin
            buf_full_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         buf_full_q <= 1'b0;
         buf_data_q <= '0;
         phase_q    <= '0;
         data_q     <= '0;
         for (int k = 0; k < CIC_STAGES; k++) begin
            integ_q[k] <= '0;
            for (int j = 0; j < DIFFERENTIAL_DELAY; j++) dly_q[k][j] <= '0;
         end
      end else begin
         buf_full_q <= buf_full_d;
         buf_data_q <= buf_data_d;
         phase_q    <= phase_d;
         data_q     <= data_d;
         integ_q    <= integ_d;
         dly_q      <= dly_d;
      end
   end

   assign o_data  = data_q;
   assign o_phase = phase_q;

endmodule
`default_nettype wire
